// File: rtl/conv_pkg.sv
// Shared encodings for the conv load scheduler: command opcodes and FSM states.
package conv_pkg;

   typedef enum logic [1:0] {
      OP_LD_WEI = 2'd0,
      OP_LD_FTM = 2'd1,
      OP_CLEAR  = 2'd2,
      OP_START  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_WEI,
      S_LD_FTM,
      S_CLR,
      S_WAIT_START
   } state_e;

endpackage

// File: rtl/conv_beat_counter.sv
// Remaining-beat counter for a load: loaded with the command length, stepped on each accepted beat.
module conv_beat_counter #(
   parameter int unsigned B_LEN = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [B_LEN-1:0] i_len,
   input  logic             i_dec,
   output logic             o_last
);

   logic [B_LEN-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_len;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - B_LEN'(1);
      end
   end

   assign o_last = (r_cnt == B_LEN'(1));

endmodule

// File: rtl/conv_load_scheduler.sv
// Command sequencer between the DDR read stream and the conv units: weight/feature-map loads,
// buffer clears and a gated compute start, with stream throttling on per-unit full flags.
module conv_load_scheduler
   import conv_pkg::*;
#(
   parameter int unsigned N_CONV_UNIT = 8,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned B_LEN       = 16,
   parameter int unsigned B_UNIT      = $clog2(N_CONV_UNIT)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   halt,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [B_UNIT-1:0]      cmd_unit,
   input  logic [B_LEN-1:0]       cmd_len,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   output logic [DATA_WIDTH-1:0]  di,
   output logic [N_CONV_UNIT-1:0] fb_we,
   output logic [N_CONV_UNIT-1:0] wb_we,
   output logic                   fb_clr,
   output logic                   wb_clr,
   output logic                   start,
   input  logic [N_CONV_UNIT-1:0] fb_full,
   input  logic [N_CONV_UNIT-1:0] wb_full,
   input  logic [N_CONV_UNIT-1:0] fb_suff,
   input  logic [N_CONV_UNIT-1:0] wb_suff,
   output logic                   done,
   output logic                   err,
   output logic                   busy
);

   localparam logic [N_CONV_UNIT-1:0] UNIT_ONE = {{(N_CONV_UNIT-1){1'b0}}, 1'b1};

   state_e              r_state, w_next;
   logic [B_UNIT-1:0]   r_unit;
   logic                r_done, r_err, r_start, r_clr;

   logic                w_accept, w_xfer, w_last, w_bad_unit, w_load;
   logic                w_done_set, w_err_set, w_start_set, w_clr_set;
   logic [N_CONV_UNIT-1:0] w_unit_mask;

   conv_beat_counter #(
      .B_LEN (B_LEN)
   ) u_beat_counter (
      .clk     (clk),
      .rstn    (rstn),
      .i_clear (halt),
      .i_load  (w_load),
      .i_len   (cmd_len),
      .i_dec   (w_xfer),
      .o_last  (w_last)
   );

   // Shift-based select keeps out-of-range unit values harmless for any B_UNIT width.
   assign w_unit_mask = UNIT_ONE << r_unit;
   assign w_bad_unit  = ({1'b0, cmd_unit} >= (B_UNIT+1)'(N_CONV_UNIT));

   always_comb begin
      cmd_ready = (r_state == S_IDLE) && !halt;
      w_accept  = cmd_valid && cmd_ready;

      s_ready = 1'b0;
      case (r_state)
         S_LD_WEI: s_ready = ~|(wb_full & w_unit_mask);
         S_LD_FTM: s_ready = ~|fb_full;
         default:  s_ready = 1'b0;
      endcase
      if (halt) s_ready = 1'b0;

      w_xfer = s_valid && s_ready;
      di     = w_xfer ? s_data : '0;
      wb_we  = (w_xfer && (r_state == S_LD_WEI)) ? w_unit_mask : '0;
      fb_we  = (w_xfer && (r_state == S_LD_FTM)) ? '1 : '0;
   end

   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_done_set  = 1'b0;
      w_err_set   = 1'b0;
      w_start_set = 1'b0;
      w_clr_set   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (op_e'(cmd_op))
                  OP_LD_WEI: begin
                     if (w_bad_unit) begin
                        w_err_set = 1'b1;
                     end else if (cmd_len == '0) begin
                        w_done_set = 1'b1;
                     end else begin
                        w_load = 1'b1;
                        w_next = S_LD_WEI;
                     end
                  end
                  OP_LD_FTM: begin
                     if (cmd_len == '0) begin
                        w_done_set = 1'b1;
                     end else begin
                        w_load = 1'b1;
                        w_next = S_LD_FTM;
                     end
                  end
                  OP_CLEAR: w_next = S_CLR;
                  OP_START: w_next = S_WAIT_START;
                  default:  w_next = S_IDLE;
               endcase
            end
         end
         S_LD_WEI, S_LD_FTM: begin
            if (w_xfer && w_last) begin
               w_done_set = 1'b1;
               w_next     = S_IDLE;
            end
         end
         S_CLR: begin
            w_clr_set = 1'b1;
            w_next    = S_IDLE;
         end
         S_WAIT_START: begin
            if ((&fb_suff) && (&wb_suff)) begin
               w_start_set = 1'b1;
               w_next      = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase

      // Halt overrides every transition and suppresses any pulse this cycle would launch.
      if (halt) begin
         w_next      = S_IDLE;
         w_load      = 1'b0;
         w_done_set  = 1'b0;
         w_err_set   = 1'b0;
         w_start_set = 1'b0;
         w_clr_set   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_unit  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_start <= 1'b0;
         r_clr   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_load) r_unit <= cmd_unit;
         r_err   <= w_err_set;
         r_start <= w_start_set;
         r_clr   <= w_clr_set;
         // Clear and start report completion one cycle after their own pulse.
         r_done  <= w_done_set | r_clr | r_start;
      end
   end

   assign done   = r_done;
   assign err    = r_err;
   assign start  = r_start;
   assign fb_clr = r_clr;
   assign wb_clr = r_clr;
   assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_load_scheduler.sv
// Directed bench for conv_load_scheduler; unit index widened to 4 bits so an out-of-range unit can be issued.
module tb_conv_load_scheduler;

   localparam int unsigned N  = 8;
   localparam int unsigned DW = 64;
   localparam int unsigned BL = 16;
   localparam int unsigned BU = 4;

   logic          clk = 1'b0;
   logic          rstn, halt, cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [BU-1:0] cmd_unit;
   logic [BL-1:0] cmd_len;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_data, di;
   logic [N-1:0]  fb_we, wb_we, fb_full, wb_full, fb_suff, wb_suff;
   logic          fb_clr, wb_clr, start, done, err, busy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   conv_load_scheduler #(
      .N_CONV_UNIT (N),
      .DATA_WIDTH  (DW),
      .B_LEN       (BL),
      .B_UNIT      (BU)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .halt      (halt),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_unit  (cmd_unit),
      .cmd_len   (cmd_len),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .di        (di),
      .fb_we     (fb_we),
      .wb_we     (wb_we),
      .fb_clr    (fb_clr),
      .wb_clr    (wb_clr),
      .start     (start),
      .fb_full   (fb_full),
      .wb_full   (wb_full),
      .fb_suff   (fb_suff),
      .wb_suff   (wb_suff),
      .done      (done),
      .err       (err),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Inputs change at the falling edge; outputs are sampled 1ns later, away from the rising edge.
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [BU-1:0] unit, input logic [BL-1:0] len);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_unit  = unit;
      cmd_len   = len;
      #1;
      check("cmd_ready_at_issue", {63'd0, cmd_ready}, 64'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
   endtask

   initial begin
      rstn = 1'b0; halt = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_unit = '0; cmd_len = '0;
      s_valid = 1'b0; s_data = '0; fb_full = '0; wb_full = '0; fb_suff = '0; wb_suff = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_busy",      {63'd0, busy}, 64'd0);
      check("rst_s_ready",   {63'd0, s_ready}, 64'd0);
      check("rst_pulses",    {59'd0, done, err, start, fb_clr, wb_clr}, 64'd0);
      check("rst_we",        {48'd0, fb_we, wb_we}, 64'd0);
      check("rst_di",        di, 64'd0);

      // 1: LD_WEI unit 2, four beats back to back
      s_valid = 1'b1;
      s_data  = 64'hFFFF_0000_0000_0000;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_unit = 4'd2; cmd_len = 16'd4;
      #1;
      check("t1_idle_no_we", {56'd0, wb_we}, 64'd0);
      check("t1_idle_di",    di, 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         s_data    = 64'h1111_2222_0000_0000 + 64'(i);
         #1;
         check("t1_wb_we",  {56'd0, wb_we}, 64'h04);
         check("t1_fb_we",  {56'd0, fb_we}, 64'h00);
         check("t1_di",     di, 64'h1111_2222_0000_0000 + 64'(i));
         check("t1_done_lo", {63'd0, done}, 64'd0);
      end
      next_cycle();
      check("t1_done",     {63'd0, done}, 64'd1);
      check("t1_idle",     {63'd0, busy}, 64'd0);
      check("t1_after_we", {56'd0, wb_we}, 64'd0);
      check("t1_after_di", di, 64'd0);
      next_cycle();
      check("t1_done_once", {63'd0, done}, 64'd0);
      s_valid = 1'b0;

      // 2: LD_FTM len 3, unit 5 full for two cycles mid-transfer
      s_valid = 1'b1;
      s_data  = 64'hB0;
      issue(2'd1, 4'd0, 16'd3);
      check("t2_b0_we", {56'd0, fb_we}, 64'hFF);
      check("t2_b0_di", di, 64'hB0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         fb_full = 8'h20;
         s_data  = 64'hB1;
         #1;
         check("t2_stall_ready", {63'd0, s_ready}, 64'd0);
         check("t2_stall_we",    {56'd0, fb_we}, 64'h00);
         check("t2_stall_di",    di, 64'd0);
      end
      @(negedge clk);
      fb_full = '0;
      #1;
      check("t2_b1_we", {56'd0, fb_we}, 64'hFF);
      check("t2_b1_di", di, 64'hB1);
      @(negedge clk);
      s_data = 64'hB2;
      #1;
      check("t2_b2_we",   {56'd0, fb_we}, 64'hFF);
      check("t2_b2_wbwe", {56'd0, wb_we}, 64'h00);
      next_cycle();
      check("t2_done",  {63'd0, done}, 64'd1);
      check("t2_no_we", {56'd0, fb_we}, 64'h00);
      s_valid = 1'b0;
      next_cycle();

      // 3: START blocked by wb_suff[7]
      fb_suff = 8'hFF;
      wb_suff = 8'h7F;
      issue(2'd3, 4'd0, 16'd0);
      for (int i = 0; i < 10; i++) begin
         check("t3_start_lo", {63'd0, start}, 64'd0);
         check("t3_busy",     {63'd0, busy}, 64'd1);
         next_cycle();
      end
      wb_suff = 8'hFF;
      #1;
      check("t3_start_not_yet", {63'd0, start}, 64'd0);
      next_cycle();
      check("t3_start",   {63'd0, start}, 64'd1);
      check("t3_done_lo", {63'd0, done}, 64'd0);
      next_cycle();
      check("t3_start_once", {63'd0, start}, 64'd0);
      check("t3_done",       {63'd0, done}, 64'd1);
      next_cycle();
      check("t3_done_once", {63'd0, done}, 64'd0);
      fb_suff = '0;
      wb_suff = '0;

      // 4: LD_WEI to nonexistent unit 9
      s_valid = 1'b1;
      s_data  = 64'hDEAD;
      issue(2'd0, 4'd9, 16'd2);
      check("t4_err",       {63'd0, err}, 64'd1);
      check("t4_no_we",     {48'd0, fb_we, wb_we}, 64'd0);
      check("t4_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("t4_not_busy",  {63'd0, busy}, 64'd0);
      next_cycle();
      check("t4_err_once", {63'd0, err}, 64'd0);
      check("t4_no_done",  {63'd0, done}, 64'd0);

      // 5: halt on the second beat of LD_FTM len 8
      s_data = 64'h51;
      issue(2'd1, 4'd0, 16'd8);
      check("t5_b0_we", {56'd0, fb_we}, 64'hFF);
      @(negedge clk);
      halt   = 1'b1;
      s_data = 64'h52;
      #1;
      check("t5_halt_ready", {63'd0, s_ready}, 64'd0);
      check("t5_halt_we",    {56'd0, fb_we}, 64'h00);
      check("t5_halt_di",    di, 64'd0);
      @(negedge clk);
      halt = 1'b0;
      #1;
      check("t5_idle",      {63'd0, busy}, 64'd0);
      check("t5_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("t5_no_done",   {63'd0, done}, 64'd0);
      check("t5_no_we",     {56'd0, fb_we}, 64'h00);
      next_cycle();
      check("t5_no_done2", {63'd0, done}, 64'd0);

      // 6: CLEAR, then zero-length loads
      s_valid = 1'b0;
      issue(2'd2, 4'd0, 16'd0);
      check("t6_clr_state_busy", {63'd0, busy}, 64'd1);
      check("t6_clr_not_yet",    {62'd0, fb_clr, wb_clr}, 64'd0);
      next_cycle();
      check("t6_clr",      {62'd0, fb_clr, wb_clr}, 64'd3);
      check("t6_clr_done", {63'd0, done}, 64'd0);
      next_cycle();
      check("t6_clr_once", {62'd0, fb_clr, wb_clr}, 64'd0);
      check("t6_done",     {63'd0, done}, 64'd1);
      next_cycle();
      check("t6_done_once", {63'd0, done}, 64'd0);

      s_valid = 1'b1;
      s_data  = 64'h60;
      issue(2'd0, 4'd1, 16'd0);
      check("t6_wei0_done", {63'd0, done}, 64'd1);
      check("t6_wei0_busy", {63'd0, busy}, 64'd0);
      check("t6_wei0_we",   {56'd0, wb_we}, 64'h00);
      issue(2'd1, 4'd0, 16'd0);
      check("t6_ftm0_done",  {63'd0, done}, 64'd1);
      check("t6_ftm0_we",    {56'd0, fb_we}, 64'h00);
      check("t6_ftm0_ready", {63'd0, s_ready}, 64'd0);
      next_cycle();
      check("t6_ftm0_done_once", {63'd0, done}, 64'd0);

      // Reset in the middle of a load drops it
      s_data = 64'h70;
      issue(2'd1, 4'd0, 16'd5);
      check("t7_beat", {56'd0, fb_we}, 64'hFF);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("t7_busy",      {63'd0, busy}, 64'd0);
      check("t7_ready",     {63'd0, s_ready}, 64'd0);
      check("t7_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("t7_we",        {48'd0, fb_we, wb_we}, 64'd0);
      s_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
